uart_sample_packer: RTL
=======================

# uart_sample_packer

Byte-to-sample depacketizer that sits directly downstream of the UART receiver. It consumes received bytes with their valid and frame-error strobes and parses framed packets: sync byte, length, then little-endian 16-bit audio samples, optionally followed by a checksum. Recovered samples are buffered in a first-word-fall-through FIFO with a valid/ready handshake toward the feature-extraction front end.

## Interface
- `SYNC_BYTE`, default `8'hA5`: packet start marker.
- `FIFO_DEPTH`, default `8`: sample FIFO entries; must be a power of two and at least 2.
- `CLK` in, 1 bit: system clock; all logic is on the rising edge.
- `RST_N` in, 1 bit: reset, asynchronous and active-low.
- `RX_DATA` in, 8 bits: received byte, meaningful only while `RX_VLD` is high.
- `RX_VLD` in, 1 bit: single-cycle byte strobe.
- `RX_FRAME_ERROR` in, 1 bit: single-cycle UART framing-error strobe.
- `SAMPLE_OUT` out, 16 bits: FIFO head sample.
- `SAMPLE_VLD` out, 1 bit: FIFO is not empty.
- `SAMPLE_RDY` in, 1 bit: consumer ready; a pop occurs when `SAMPLE_VLD & SAMPLE_RDY`.
- `FIFO_LEVEL` out, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
- `PKT_DONE` out, 1 bit: one-cycle pulse on a good packet end.
- `PKT_ERROR` out, 1 bit: one-cycle pulse on a packet abort.
- `ERR_CODE` out, 2 bits: abort cause, valid with `PKT_ERROR` and held until the next abort.
  - 0 = zero length
  - 1 = framing error
  - 2 = checksum mismatch
  - 3 = FIFO overflow

## Operation
- **Reset values (`RST_N` low):** state IDLE; FIFO empty; `SAMPLE_VLD`=0, `SAMPLE_OUT`=0, `FIFO_LEVEL`=0, `PKT_DONE`=0, `PKT_ERROR`=0, `ERR_CODE`=0; counters and checksum cleared.
- **States:** IDLE, LEN, LO, HI, CSUM. Transitions happen only on edges where `RX_VLD`=1, except for the abort rules below.
- **IDLE:**
  - A byte equal to `SYNC_BYTE` moves to LEN.
  - Any other byte is silently discarded.
- **LEN:** the byte is latched as N (count of 16-bit samples, 1..255) and the checksum accumulator is loaded with N.
  - N=0: abort with code 0, return to IDLE.
  - Otherwise go to LO.
- **LO:** latch the low byte, add it to the accumulator, go to HI.
- **HI:** form `{byte, low}`, add the byte to the accumulator, push the sample and decrement the remaining count.
  - Remaining count reaches 0: go to CSUM (macro defined) or to IDLE with `PKT_DONE` (macro undefined).
  - Otherwise go to LO.
- **CSUM:** compare the byte with the accumulator (8-bit sum, mod 256, of N and all payload bytes).
  - Equal: `PKT_DONE`.
  - Not equal: abort with code 2.
  - Either way, return to IDLE.
- **Framing error:** `RX_FRAME_ERROR`=1 in any state other than IDLE aborts with code 1 and returns to IDLE. In IDLE it is ignored. If `RX_VLD` and `RX_FRAME_ERROR` are both high, the byte is discarded and the abort wins.
- **Overflow:** a HI-byte push while the FIFO is full and no pop occurs in the same cycle drops the sample, aborts with code 3 and returns to IDLE.
  - A push and a pop in the same cycle on a full FIFO are both accepted; the level is unchanged.
- **Partial packets:** samples already pushed from a packet that later aborts stay in the FIFO. The consumer uses `PKT_ERROR` to discard them.
- **FIFO behaviour:**
  - First-word fall-through: `SAMPLE_OUT` is valid whenever `SAMPLE_VLD`=1 and holds stable until popped.
  - A pop on an empty FIFO is impossible because `SAMPLE_VLD` gates it.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- A byte is accepted at the edge where `RX_VLD`=1 is sampled.
- For a HI byte accepted at edge k, the FIFO write happens at edge k. If the FIFO was empty, `SAMPLE_VLD`=1 and `SAMPLE_OUT` show the new sample in cycle k+1. Latency is 1 cycle.
- `PKT_DONE`, `PKT_ERROR` and `ERR_CODE` are registered. They assert in the cycle after the completing or aborting byte or error strobe, and each pulse lasts exactly 1 cycle.
- A pop at edge k updates `SAMPLE_OUT`, `SAMPLE_VLD` and `FIFO_LEVEL` in cycle k+1.
- Back-to-back packets need no gap: a sync byte is accepted the cycle after the packet ends.
- Asserting reset mid-packet or with a non-empty FIFO clears everything immediately. No pulse is emitted.

## Configuration
- Macro: `UART_PKT_CHECKSUM_EN`.
- **Defined:** the CSUM state exists; a trailing checksum byte is mandatory and is verified; error code 2 can occur.
- **Undefined:** there is no CSUM state and no accumulator logic; `PKT_DONE` pulses after the last HI byte; error code 2 never occurs.

## Test plan
- Checksum enabled, `SAMPLE_RDY`=1, bytes A5 02 34 12 78 56 16 → samples 0x1234 then 0x5678, one `PKT_DONE`, no `PKT_ERROR`.
- Same packet with checksum byte 17 → both samples are still output, then `PKT_ERROR` with `ERR_CODE`=2.
- Bytes 00 FF A5 00 → first two bytes ignored, then `PKT_ERROR` with `ERR_CODE`=0; state back in IDLE.
- `RX_FRAME_ERROR` pulse after A5 03 34 → `PKT_ERROR` with `ERR_CODE`=1; no sample pushed; a following good packet parses normally.
- `FIFO_DEPTH`=8, `SAMPLE_RDY`=0, packet of N=9 → `FIFO_LEVEL`=8, 9th sample dropped, `ERR_CODE`=3. Then raise `SAMPLE_RDY` → the 8 samples drain in order, one per cycle.
- Reset low mid-packet with 3 samples buffered → `SAMPLE_VLD`=0 and `FIFO_LEVEL`=0 immediately; after release a new packet is accepted.

Source files
------------

// File: rtl/uart_sample_packer.sv
// UART byte-stream depacketizer: SYNC, LEN, then little-endian 16-bit samples into a FWFT FIFO.
// Optional trailing checksum byte enabled by `define UART_PKT_CHECKSUM_EN.
module uart_sample_packer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [7:0]                    RX_DATA,
  input  logic                          RX_VLD,
  input  logic                          RX_FRAME_ERROR,
  output logic [15:0]                   SAMPLE_OUT,
  output logic                          SAMPLE_VLD,
  input  logic                          SAMPLE_RDY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          PKT_DONE,
  output logic                          PKT_ERROR,
  output logic [1:0]                    ERR_CODE,
  output logic [2:0]                    STATE_DBG
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_LO   = 3'd2,
`ifdef UART_PKT_CHECKSUM_EN
    S_HI   = 3'd3,
    S_CSUM = 3'd4
`else
    S_HI   = 3'd3
`endif
  } state_t;

  state_t      state, state_n;
  logic [7:0]  remain, remain_n;
  logic [7:0]  low_byte, low_byte_n;
  logic        done_n, err_n;
  logic [1:0]  code_n;
  logic        push;
  logic        pop;
  logic        full;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] csum, csum_n;
`endif

  // Output handshake: a sample transfers on any rising edge where SAMPLE_VLD and SAMPLE_RDY
  // are both high; SAMPLE_OUT is stable while SAMPLE_VLD is high and not yet accepted.
  assign SAMPLE_VLD = (level != '0);
  assign SAMPLE_OUT = SAMPLE_VLD ? mem[rd_ptr] : 16'h0000;
  assign FIFO_LEVEL = level;
  assign pop        = SAMPLE_VLD & SAMPLE_RDY;
  assign full       = (level == LW'(FIFO_DEPTH));
  assign STATE_DBG  = state;

  always_comb begin
    state_n    = state;
    remain_n   = remain;
    low_byte_n = low_byte;
    done_n     = 1'b0;
    err_n      = 1'b0;
    code_n     = ERR_CODE;
    push       = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    csum_n     = csum;
`endif
    // A framing error outside IDLE wins over any byte strobed in the same cycle.
    if (state != S_IDLE && RX_FRAME_ERROR) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
      code_n  = 2'd1;
    end else if (RX_VLD) begin
      unique case (state)
        S_IDLE: begin
          if (RX_DATA == SYNC_BYTE) state_n = S_LEN;
        end
        S_LEN: begin
          remain_n = RX_DATA;
`ifdef UART_PKT_CHECKSUM_EN
          csum_n   = RX_DATA;
`endif
          if (RX_DATA == 8'd0) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            code_n  = 2'd0;
          end else begin
            state_n = S_LO;
          end
        end
        S_LO: begin
          low_byte_n = RX_DATA;
`ifdef UART_PKT_CHECKSUM_EN
          csum_n     = csum + RX_DATA;
`endif
          state_n    = S_HI;
        end
        S_HI: begin
`ifdef UART_PKT_CHECKSUM_EN
          csum_n = csum + RX_DATA;
`endif
          // A simultaneous pop frees the slot, so only a stalled full FIFO drops the sample.
          if (full && !pop) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            code_n  = 2'd3;
          end else begin
            push     = 1'b1;
            remain_n = remain - 8'd1;
            if (remain == 8'd1) begin
`ifdef UART_PKT_CHECKSUM_EN
              state_n = S_CSUM;
`else
              state_n = S_IDLE;
              done_n  = 1'b1;
`endif
            end else begin
              state_n = S_LO;
            end
          end
        end
`ifdef UART_PKT_CHECKSUM_EN
        S_CSUM: begin
          state_n = S_IDLE;
          if (RX_DATA == csum) begin
            done_n = 1'b1;
          end else begin
            err_n  = 1'b1;
            code_n = 2'd2;
          end
        end
`endif
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      remain    <= 8'd0;
      low_byte  <= 8'd0;
      PKT_DONE  <= 1'b0;
      PKT_ERROR <= 1'b0;
      ERR_CODE  <= 2'd0;
`ifdef UART_PKT_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      remain    <= remain_n;
      low_byte  <= low_byte_n;
      PKT_DONE  <= done_n;
      PKT_ERROR <= err_n;
      ERR_CODE  <= code_n;
`ifdef UART_PKT_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: SAMPLE_OUT is forced to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {RX_DATA, low_byte};
  end

endmodule
